// File: rtl/multi_queue_buffer.sv
// Shared-pool multi-queue FIFO: NUM_LISTS linked-list queues plus a free list over NUM_ELEMS data slots.
// Optional per-queue cap on push acceptance when MQB_QUOTA_EN is defined (LIST_QUOTA slots per queue).
module multi_queue_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 8,
  parameter int NUM_LISTS  = 4,
  parameter int PTR_WIDTH  = $clog2(NUM_ELEMS),
  parameter int ID_WIDTH   = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1,
  parameter int CNT_WIDTH  = PTR_WIDTH + 1,
  parameter int LIST_QUOTA = NUM_ELEMS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_valid,
  input  logic [ID_WIDTH-1:0]            push_id,
  input  logic [DATA_WIDTH-1:0]          push_data,
  output logic                           push_ready,
  input  logic                           pop_valid,
  input  logic [ID_WIDTH-1:0]            pop_id,
  output logic                           pop_ready,
  output logic [DATA_WIDTH-1:0]          pop_data,
  output logic                           full,
  output logic [NUM_LISTS-1:0]           empty,
  output logic [NUM_LISTS*CNT_WIDTH-1:0] occupancy,
  output logic [CNT_WIDTH-1:0]           total_count
);

  localparam int ID_SPAN = 1 << ID_WIDTH;

`ifdef MQB_QUOTA_EN
  localparam int QUOTA_CAP = LIST_QUOTA;
`else
  // A cap of at least NUM_ELEMS can only bite when the pool is already full.
  localparam int QUOTA_CAP = (LIST_QUOTA > NUM_ELEMS) ? LIST_QUOTA : NUM_ELEMS;
`endif

  function automatic logic [ID_SPAN-1:0] id_mask_f();
    logic [ID_SPAN-1:0] m;
    m = {ID_SPAN{1'b0}};
    for (int i = 0; i < ID_SPAN; i++) begin
      m[i] = (i < NUM_LISTS);
    end
    return m;
  endfunction

  localparam logic [ID_SPAN-1:0] ID_MASK = id_mask_f();

  logic [DATA_WIDTH-1:0] data_mem_r [NUM_ELEMS];
  logic [PTR_WIDTH-1:0]  next_ptr_r [NUM_ELEMS];
  logic [PTR_WIDTH-1:0]  head_r     [NUM_LISTS];
  logic [PTR_WIDTH-1:0]  tail_r     [NUM_LISTS];
  logic [CNT_WIDTH-1:0]  count_r    [NUM_LISTS];
  logic [CNT_WIDTH-1:0]  total_r;
  logic [PTR_WIDTH-1:0]  free_head_r;
  logic [PTR_WIDTH-1:0]  free_tail_r;

  logic                  full_s;
  logic                  free_one_s;
  logic [NUM_LISTS-1:0]  empty_s;
  logic                  push_ready_s;
  logic                  pop_ready_s;
  logic                  push_acc_s;
  logic                  pop_acc_s;
  logic                  same_one_s;
  logic [PTR_WIDTH-1:0]  pop_slot_s;
  logic [DATA_WIDTH-1:0] pop_data_s;

  // Handshake decode, head read and status derived from the current state.
  always_comb begin
    for (int i = 0; i < NUM_LISTS; i++) begin
      empty_s[i] = (count_r[i] == {CNT_WIDTH{1'b0}});
    end
    full_s     = (total_r == CNT_WIDTH'(NUM_ELEMS));
    free_one_s = (total_r == CNT_WIDTH'(NUM_ELEMS - 1));
    pop_slot_s = head_r[pop_id];
    if (rst) begin
      push_ready_s = 1'b1;
      pop_ready_s  = 1'b0;
    end else begin
      push_ready_s = !full_s && ID_MASK[push_id] && (int'(count_r[push_id]) < QUOTA_CAP);
      pop_ready_s  = pop_valid && ID_MASK[pop_id] && !empty_s[pop_id];
    end
    push_acc_s = push_valid && push_ready_s && !rst;
    pop_acc_s  = pop_ready_s;
    // Pop takes the only node while push appends to the same queue: the new slot becomes head.
    same_one_s = push_acc_s && pop_acc_s && (push_id == pop_id) &&
                 (count_r[pop_id] == CNT_WIDTH'(1));
    if (pop_ready_s) begin
      pop_data_s = data_mem_r[pop_slot_s];
    end else begin
      pop_data_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Link structure, free list and occupancy counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_ELEMS; j++) begin
        next_ptr_r[j] <= PTR_WIDTH'((j + 1) % NUM_ELEMS);
      end
      for (int i = 0; i < NUM_LISTS; i++) begin
        head_r[i]  <= {PTR_WIDTH{1'b0}};
        tail_r[i]  <= {PTR_WIDTH{1'b0}};
        count_r[i] <= {CNT_WIDTH{1'b0}};
      end
      total_r     <= {CNT_WIDTH{1'b0}};
      free_head_r <= {PTR_WIDTH{1'b0}};
      free_tail_r <= PTR_WIDTH'(NUM_ELEMS - 1);
    end else begin
      if (push_acc_s) begin
        tail_r[push_id] <= free_head_r;
        free_head_r     <= next_ptr_r[free_head_r];
        if (empty_s[push_id] || same_one_s) begin
          head_r[push_id] <= free_head_r;
        end else begin
          next_ptr_r[tail_r[push_id]] <= free_head_r;
        end
      end
      if (pop_acc_s) begin
        if (!same_one_s) begin
          head_r[pop_id] <= next_ptr_r[pop_slot_s];
        end
        free_tail_r <= pop_slot_s;
        // Free list empty now or emptied by this cycle's push: released slot is the whole list.
        if (full_s || (push_acc_s && free_one_s)) begin
          free_head_r <= pop_slot_s;
        end else begin
          next_ptr_r[free_tail_r] <= pop_slot_s;
        end
      end
      for (int i = 0; i < NUM_LISTS; i++) begin
        count_r[i] <= count_r[i]
                      + CNT_WIDTH'(push_acc_s && (push_id == ID_WIDTH'(i)))
                      - CNT_WIDTH'(pop_acc_s && (pop_id == ID_WIDTH'(i)));
      end
      total_r <= total_r + CNT_WIDTH'(push_acc_s) - CNT_WIDTH'(pop_acc_s);
    end
  end

  // Payload storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      data_mem_r[free_head_r] <= push_data;
    end
  end

  // Pack per-queue counts onto the occupancy bus.
  always_comb begin
    occupancy = {(NUM_LISTS*CNT_WIDTH){1'b0}};
    for (int i = 0; i < NUM_LISTS; i++) begin
      occupancy[i*CNT_WIDTH +: CNT_WIDTH] = count_r[i];
    end
  end

  assign push_ready  = push_ready_s;
  assign pop_ready   = pop_ready_s;
  assign pop_data    = pop_data_s;
  assign full        = full_s;
  assign empty       = empty_s;
  assign total_count = total_r;

endmodule

// File: tb/tb_multi_queue_buffer.sv
// Self-checking bench for multi_queue_buffer: per-queue scoreboard of expected payloads,
// handshakes predicted from the model and compared each cycle.
module tb_multi_queue_buffer;

  localparam int DW    = 8;
  localparam int NE    = 8;
  localparam int NL    = 4;
  localparam int CW    = 4;
  localparam int QUOTA = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push_valid = 1'b0;
  logic [1:0]       push_id = 2'd0;
  logic [DW-1:0]    push_data = 8'h00;
  logic             push_ready;
  logic             pop_valid = 1'b0;
  logic [1:0]       pop_id = 2'd0;
  logic             pop_ready;
  logic [DW-1:0]    pop_data;
  logic             full;
  logic [NL-1:0]    empty;
  logic [NL*CW-1:0] occupancy;
  logic [CW-1:0]    total_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb_q [NL][$];

  always #5 clk = ~clk;

  multi_queue_buffer #(
    .DATA_WIDTH(DW), .NUM_ELEMS(NE), .NUM_LISTS(NL), .LIST_QUOTA(QUOTA)
  ) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_id(push_id), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_id(pop_id), .pop_ready(pop_ready), .pop_data(pop_data),
    .full(full), .empty(empty), .occupancy(occupancy), .total_count(total_count)
  );

  function automatic int model_total();
    int t = 0;
    for (int i = 0; i < NL; i++) t += sb_q[i].size();
    return t;
  endfunction

  // One clock of stimulus; handshakes and pop payload predicted from the scoreboard.
  task automatic cycle(input bit pv, input int pid, input logic [7:0] pd, input bit ov, input int oid);
    logic exp_pr, exp_or;
    logic [7:0] exp_pd;
    @(negedge clk);
    push_valid = pv; push_id = 2'(pid); push_data = pd;
    pop_valid = ov; pop_id = 2'(oid);
    #1;
    exp_pr = (model_total() < NE);
`ifdef MQB_QUOTA_EN
    if (sb_q[pid].size() >= QUOTA) exp_pr = 1'b0;
`endif
    exp_or = ov && (sb_q[oid].size() > 0);
    exp_pd = exp_or ? sb_q[oid][0] : 8'h00;
    checks++;
    if (push_ready !== exp_pr) begin
      errors++; $display("FAIL push_ready q%0d got=%b exp=%b", pid, push_ready, exp_pr);
    end
    checks++;
    if (pop_ready !== exp_or) begin
      errors++; $display("FAIL pop_ready q%0d got=%b exp=%b", oid, pop_ready, exp_or);
    end
    checks++;
    if (pop_data !== exp_pd) begin
      errors++; $display("FAIL pop_data q%0d got=%h exp=%h", oid, pop_data, exp_pd);
    end
    @(posedge clk);
    if (exp_or) void'(sb_q[oid].pop_front());
    if (pv && exp_pr) sb_q[pid].push_back(pd);
    #1;
    push_valid = 1'b0; pop_valid = 1'b0;
    checks++;
    if (total_count !== 4'(model_total())) begin
      errors++; $display("FAIL total_count got=%0d exp=%0d", total_count, model_total());
    end
    for (int i = 0; i < NL; i++) begin
      checks++;
      if (occupancy[i*CW +: CW] !== 4'(sb_q[i].size())) begin
        errors++; $display("FAIL occupancy q%0d got=%0d exp=%0d", i, occupancy[i*CW +: CW], sb_q[i].size());
      end
    end
  endtask

  task automatic drain();
    for (int q = 0; q < NL; q++) begin
      while (sb_q[q].size() > 0) cycle(1'b0, 0, 8'h00, 1'b1, q);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    push_valid = 1'b1; pop_valid = 1'b1; pop_id = 2'd2;
    #1;
    checks++;
    if (push_ready !== 1'b1) begin errors++; $display("FAIL rst_push_ready got=%b exp=1", push_ready); end
    checks++;
    if (pop_ready !== 1'b0) begin errors++; $display("FAIL rst_pop_ready got=%b exp=0", pop_ready); end
    checks++;
    if (pop_data !== 8'h00) begin errors++; $display("FAIL rst_pop_data got=%h exp=00", pop_data); end
    checks++;
    if (empty !== 4'hF) begin errors++; $display("FAIL rst_empty got=%h exp=F", empty); end
    checks++;
    if (total_count !== 4'd0 || full !== 1'b0) begin
      errors++; $display("FAIL rst_total got=%0d/%b exp=0/0", total_count, full);
    end
    @(negedge clk);
    rst = 1'b0; push_valid = 1'b0; pop_valid = 1'b0;
    for (int i = 0; i < NL; i++) sb_q[i].delete();
  endtask

  task automatic test_fifo_order();
    cycle(1'b1, 2, 8'hA1, 1'b0, 0);
    cycle(1'b1, 2, 8'hA2, 1'b0, 0);
    cycle(1'b1, 2, 8'hA3, 1'b0, 0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 0, 8'h00, 1'b1, 2);
    checks++;
    if (empty[2] !== 1'b1 || total_count !== 4'd0) begin
      errors++; $display("FAIL fifo_drained empty2=%b total=%0d exp=1/0", empty[2], total_count);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < NE; i++) cycle(1'b1, i % NL, 8'(8'h30 + i), 1'b0, 0);
    checks++;
    if (full !== 1'b1 || push_ready !== 1'b0) begin
      errors++; $display("FAIL full_after_8 full=%b push_ready=%b exp=1/0", full, push_ready);
    end
    cycle(1'b0, 0, 8'h00, 1'b1, 1);
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL full_after_pop got=%b exp=0", full); end
    cycle(1'b1, 1, 8'h40, 1'b0, 0);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full_after_9th got=%b exp=1", full); end
    drain();
  endtask

  task automatic test_same_queue();
    cycle(1'b1, 0, 8'h11, 1'b0, 0);
    cycle(1'b1, 0, 8'h22, 1'b1, 0);
    checks++;
    if (occupancy[3:0] !== 4'd1) begin errors++; $display("FAIL swap_count got=%0d exp=1", occupancy[3:0]); end
    cycle(1'b0, 0, 8'h00, 1'b1, 0);
    checks++;
    if (empty[0] !== 1'b1) begin errors++; $display("FAIL swap_empty got=%b exp=1", empty[0]); end
  endtask

  task automatic test_near_full();
    int ids [7] = '{0, 0, 1, 1, 2, 2, 3};
    for (int i = 0; i < 7; i++) cycle(1'b1, ids[i], 8'(8'h60 + i), 1'b0, 0);
    cycle(1'b1, 3, 8'h55, 1'b1, 0);
    checks++;
    if (total_count !== 4'd7) begin errors++; $display("FAIL nearfull_total got=%0d exp=7", total_count); end
    cycle(1'b1, 2, 8'h66, 1'b0, 0);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL nearfull_full got=%b exp=1", full); end
    drain();
    checks++;
    if (total_count !== 4'd0) begin errors++; $display("FAIL nearfull_drain got=%0d exp=0", total_count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b1, i % NL, 8'(8'h80 + i), 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) sb_q[i].delete();
    checks++;
    if (empty !== 4'hF || total_count !== 4'd0) begin
      errors++; $display("FAIL midrst_state empty=%h total=%0d exp=F/0", empty, total_count);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (push_ready !== 1'b1) begin errors++; $display("FAIL midrst_push_ready got=%b exp=1", push_ready); end
    cycle(1'b1, 3, 8'h9C, 1'b0, 0);
    cycle(1'b0, 0, 8'h00, 1'b1, 3);
  endtask

  task automatic test_quota();
`ifdef MQB_QUOTA_EN
    for (int i = 0; i < 4; i++) cycle(1'b1, 1, 8'(8'h71 + i), 1'b0, 0);
    checks++;
    if (occupancy[7:4] !== 4'd3) begin errors++; $display("FAIL quota_q1 got=%0d exp=3", occupancy[7:4]); end
    cycle(1'b1, 0, 8'h75, 1'b0, 0);
    checks++;
    if (occupancy[3:0] !== 4'd1) begin errors++; $display("FAIL quota_q0 got=%0d exp=1", occupancy[3:0]); end
`else
    for (int i = 0; i < NE; i++) cycle(1'b1, 1, 8'(8'h71 + i), 1'b0, 0);
    checks++;
    if (full !== 1'b1 || occupancy[7:4] !== 4'd8) begin
      errors++; $display("FAIL noquota_q1 full=%b count=%0d exp=1/8", full, occupancy[7:4]);
    end
`endif
    drain();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_full();
    test_same_queue();
    test_near_full();
    test_reset_mid();
    test_quota();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
